// File: rtl/cordic_pipe.sv
`timescale 1ns/1ps
// Fully pipelined CORDIC (rotation/vectoring per sample) with quadrant pre-rotation; latency ITER+1 (ITER+2 with CORDIC_GAIN_COMP_EN).
// Backpressure: global stall, the whole pipe freezes while valid_o=1 and ready_i=0; ready_o = ready_i | ~valid_o.
module cordic_pipe #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int ITER = 14
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            mode_i,
    input  logic [DW-1:0]   x_i,
    input  logic [DW-1:0]   y_i,
    input  logic [AW-1:0]   a_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            mode_o,
    output logic [DW+1:0]   x_o,
    output logic [DW+1:0]   y_o,
    output logic [AW-1:0]   a_o
);
    localparam int IW = DW + 2;
    localparam logic signed [AW-1:0] QTR = {2'b01, {(AW-2){1'b0}}};

    typedef logic [ITER-1:0][AW-1:0] atan_tab_t;

    function automatic atan_tab_t build_atan();
        atan_tab_t t;
        real       r;
        t = '0;
        for (int i = 0; i < ITER; i++) begin
            r    = $atan(2.0 ** (-i)) / 3.141592653589793 * (2.0 ** (AW - 1));
            t[i] = AW'($rtoi(r + 0.5));
        end
        return t;
    endfunction

    localparam atan_tab_t ATAN = build_atan();

    logic                 en;
    logic [ITER:0]        vld_q, vld_d, mode_q, mode_d;
    logic signed [IW-1:0] x_q [0:ITER];
    logic signed [IW-1:0] y_q [0:ITER];
    logic signed [AW-1:0] a_q [0:ITER];
    logic signed [IW-1:0] x_d [0:ITER];
    logic signed [IW-1:0] y_d [0:ITER];
    logic signed [AW-1:0] a_d [0:ITER];
    logic signed [IW-1:0] xs, ys;
    logic [ITER-1:0]      dir;

    assign xs = {{2{x_i[DW-1]}}, x_i};
    assign ys = {{2{y_i[DW-1]}}, y_i};

    always_comb begin
        vld_d  = {vld_q[ITER-1:0], valid_i};
        mode_d = {mode_q[ITER-1:0], mode_i};
        dir    = '0;
        x_d[0] = xs;
        y_d[0] = ys;
        a_d[0] = a_i;
        // Quadrant fold keeps the micro-rotations inside their +-99.9 deg reach
        if (!mode_i) begin
            if (a_i[AW-1:AW-2] == 2'b01) begin
                x_d[0] = -ys;
                y_d[0] = xs;
                a_d[0] = a_i - QTR;
            end else if (a_i[AW-1:AW-2] == 2'b10) begin
                x_d[0] = ys;
                y_d[0] = -xs;
                a_d[0] = a_i + QTR;
            end
        end else if (xs[IW-1]) begin
            if (!ys[IW-1]) begin
                x_d[0] = ys;
                y_d[0] = -xs;
                a_d[0] = a_i + QTR;
            end else begin
                x_d[0] = -ys;
                y_d[0] = xs;
                a_d[0] = a_i - QTR;
            end
        end
        for (int i = 0; i < ITER; i++) begin
            dir[i] = mode_q[i] ? y_q[i][IW-1] : ~a_q[i][AW-1];
            if (dir[i]) begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
                a_d[i+1] = a_q[i] - ATAN[i];
            end else begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
                a_d[i+1] = a_q[i] + ATAN[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int i = 0; i <= ITER; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                a_q[i] <= '0;
            end
        end else if (en) begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            for (int i = 0; i <= ITER; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
                a_q[i] <= a_d[i];
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // K = 0.60725 in Q15, rounded by adding half an LSB before the shift
    localparam logic signed [IW+16:0] GK  = (IW+17)'(19898);
    localparam logic signed [IW+16:0] RND = (IW+17)'(16384);

    logic                 g_vld_q, g_mode_q;
    logic signed [IW-1:0] gx_q, gy_q, gx_d, gy_d;
    logic [AW-1:0]        ga_q;

    always_comb begin
        gx_d = IW'((((IW+17)'(x_q[ITER]) * GK) + RND) >>> 15);
        gy_d = IW'((((IW+17)'(y_q[ITER]) * GK) + RND) >>> 15);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            g_vld_q  <= 1'b0;
            g_mode_q <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            ga_q     <= '0;
        end else if (en) begin
            g_vld_q  <= vld_q[ITER];
            g_mode_q <= mode_q[ITER];
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            ga_q     <= a_q[ITER];
        end
    end

    assign valid_o = g_vld_q;
    assign mode_o  = g_mode_q;
    assign x_o     = gx_q;
    assign y_o     = gy_q;
    assign a_o     = ga_q;
`else
    assign valid_o = vld_q[ITER];
    assign mode_o  = mode_q[ITER];
    assign x_o     = x_q[ITER];
    assign y_o     = y_q[ITER];
    assign a_o     = a_q[ITER];
`endif

    assign en      = ready_i | ~valid_o;
    assign ready_o = en;

endmodule

// File: tb/tb_cordic_pipe.sv
`timescale 1ns/1ps
// Scoreboarded bench for cordic_pipe: directed accuracy/latency cases, reset-in-flight, random stream with stalls.
module tb_cordic_pipe;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int ITER = 14;
    localparam int IW   = DW + 2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITER + 2;
    localparam bit GC  = 1'b1;
`else
    localparam int LAT = ITER + 1;
    localparam bit GC  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b1;
    logic          valid_i = 1'b0, ready_i = 1'b1, mode_i = 1'b0;
    logic [DW-1:0] x_i = '0, y_i = '0;
    logic [AW-1:0] a_i = '0;
    logic          ready_o, valid_o, mode_o;
    logic [IW-1:0] x_o, y_o;
    logic [AW-1:0] a_o;

    cordic_pipe #(.DW(DW), .AW(AW), .ITER(ITER)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .mode_i(mode_i), .x_i(x_i), .y_i(y_i), .a_i(a_i),
        .valid_o(valid_o), .ready_i(ready_i), .mode_o(mode_o),
        .x_o(x_o), .y_o(y_o), .a_o(a_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          mode;
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        logic [AW-1:0] a;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, n_out = 0, last_lat = 0;
    bit   acc_last, hold_vld = 1'b0;
    logic [IW-1:0] hx, hy;
    logic [AW-1:0] ha;
    logic          hm;
    longint lx, ly, la;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        n_chk++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int tb_atan(input int i);
        return $rtoi($atan(2.0 ** (-i)) * 32768.0 / 3.141592653589793 + 0.5);
    endfunction

    function automatic exp_t model(input bit m, input int xv, input int yv, input int av);
        exp_t r;
        logic signed [DW-1:0] xt, yt;
        logic signed [AW-1:0] a;
        longint x, y, t;
        bit d;
        xt = DW'(xv);
        yt = DW'(yv);
        a  = AW'(av);
        x  = xt;
        y  = yt;
        if (!m) begin
            if (a[AW-1:AW-2] == 2'b01) begin t = x; x = -y; y = t; a = a - 16'sd16384; end
            else if (a[AW-1:AW-2] == 2'b10) begin t = x; x = y; y = -t; a = a + 16'sd16384; end
        end else if (x < 0) begin
            if (y >= 0) begin t = x; x = y; y = -t; a = a + 16'sd16384; end
            else begin t = x; x = -y; y = t; a = a - 16'sd16384; end
        end
        for (int i = 0; i < ITER; i++) begin
            d = m ? (y < 0) : (a >= 0);
            t = x;
            if (d) begin x = x - (y >>> i); y = y + (t >>> i); a = a - AW'(tb_atan(i)); end
            else   begin x = x + (y >>> i); y = y - (t >>> i); a = a + AW'(tb_atan(i)); end
        end
        if (GC) begin
            x = (x * 19898 + 16384) >>> 15;
            y = (y * 19898 + 16384) >>> 15;
        end
        r.mode = m;
        r.x    = x[IW-1:0];
        r.y    = y[IW-1:0];
        r.a    = a;
        r.acc  = 0;
        return r;
    endfunction

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check("spurious_out", 1, 0);
        end else begin
            e = sb.pop_front();
            n_out++;
            check("x_o", longint'($signed(x_o)), longint'($signed(e.x)));
            check("y_o", longint'($signed(y_o)), longint'($signed(e.y)));
            check("a_o", longint'(a_o), longint'(e.a));
            check("mode_o", longint'(mode_o), longint'(e.mode));
            last_lat = cyc - e.acc + 1;
            lx = $signed(x_o);
            ly = $signed(y_o);
            la = $signed(a_o);
        end
    endtask

    // Called at a falling edge; inputs apply to the next rising edge
    task automatic step(input bit v, input bit m, input int xv, input int yv, input int av, input bit r);
        exp_t e;
        valid_i = v; mode_i = m; x_i = DW'(xv); y_i = DW'(yv); a_i = AW'(av); ready_i = r;
        #1;
        if (hold_vld) begin
            check("hold_vld", longint'(valid_o), 1);
            check("hold_x", longint'(x_o), longint'(hx));
            check("hold_y", longint'(y_o), longint'(hy));
            check("hold_a", longint'(a_o), longint'(ha));
            check("hold_m", longint'(mode_o), longint'(hm));
            hold_vld = 1'b0;
        end
        if (valid_o && ready_i) pop_cmp();
        if (valid_o && !ready_i) begin
            hold_vld = 1'b1; hx = x_o; hy = y_o; ha = a_o; hm = mode_o;
        end
        acc_last = valid_i && ready_o;
        if (acc_last) begin
            e     = model(m, xv, yv, av);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic one_shot(input bit m, input int xv, input int yv, input int av);
        step(1'b1, m, xv, yv, av, 1'b1);
        for (int k = 0; k < 3 * LAT && sb.size() > 0; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("drain", sb.size(), 0);
        check("latency", last_lat, LAT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xv, yv, av, sent;
        bit m, v, r;
        int x45, v5k, v10k;
        x45  = GC ? 7071 : 11645;
        v5k  = GC ? 5000 : 8234;
        v10k = GC ? 10000 : 16468;

        #2 rst_n_i = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_valid_o", longint'(valid_o), 0);
        check("rst_x_o", longint'(x_o), 0);
        check("rst_y_o", longint'(y_o), 0);
        check("rst_a_o", longint'(a_o), 0);
        check("rst_mode_o", longint'(mode_o), 0);
        @(negedge clk);
        rst_n_i = 1'b1;
        #1 check("rst_ready_o", longint'(ready_o), 1);
        @(negedge clk);

        one_shot(1'b0, 10000, 0, 8192);
        check("rot45_x", lx, x45, GC ? 6 : 10);
        check("rot45_y", ly, x45, GC ? 6 : 10);
        check("rot45_a", la, 0, 6);

        one_shot(1'b0, 10000, 0, -24576);
        check("rotm135_x", lx, -x45, GC ? 6 : 10);
        check("rotm135_y", ly, -x45, GC ? 6 : 10);

        one_shot(1'b1, 3000, 4000, 0);
        check("vec345_x", lx, v5k, GC ? 6 : 10);
        check("vec345_y", ly, 0, 6);
        check("vec345_a", la, 9672, 8);

        one_shot(1'b1, -10000, 0, 0);
        check("vecneg_x", lx, v10k, GC ? 6 : 10);
        check("vecneg_a", 32768 - (la < 0 ? -la : la), 0, 8);

        // Reset with samples in flight
        for (int k = 0; k < 5; k++) step(1'b1, k[0], 1000 * (k + 1), -500 * k, 3000 * k, 1'b1);
        for (int k = 0; k < 3 * LAT && !valid_o; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("inflight_vld", longint'(valid_o), 1);
        rst_n_i = 1'b0;
        #1;
        check("midrst_valid_o", longint'(valid_o), 0);
        check("midrst_x_o", longint'(x_o), 0);
        sb.delete();
        hold_vld = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        n_out = 0;
        step(1'b1, 1'b0, 12000, -3000, 20000, 1'b1);
        for (int k = 0; k < 2 * LAT; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b1);
        check("postrst_outs", n_out, 1);
        check("postrst_lat", last_lat, LAT);

        // Random stream with gaps and stalls
        n_out = 0;
        sent  = 0;
        m  = 1'b0; xv = 0; yv = 0; av = 0;
        v  = 1'b0;
        for (int k = 0; k < 3000 && (sent < 100 || sb.size() > 0); k++) begin
            if (!v) begin
                v  = (sent < 100) && ($urandom_range(0, 3) != 0);
                m  = 1'($urandom_range(0, 1));
                xv = int'($urandom_range(0, 65535)) - 32768;
                yv = int'($urandom_range(0, 65535)) - 32768;
                av = int'($urandom_range(0, 65535));
            end
            r = ($urandom_range(0, 3) != 0);
            step(v, m, xv, yv, av, r);
            if (acc_last) begin
                sent++;
                v = 1'b0;
            end
        end
        check("stream_sent", sent, 100);
        check("stream_outs", n_out, 100);
        check("stream_left", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
